// File: rtl/decode_ctrl.sv
// decode_ctrl: decode stage between fetch and rename. Decodes each fetched
// instruction, buffers the uops in a small FIFO and serializes BREAK/MONITOR
// by draining the ROB before issue and holding younger uops until retire/flush.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

package decode_pkg;
    typedef enum logic [3:0] {
        OP_ADDI, OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL,
        OP_BREAK, OP_MONITOR, OP_II
    } op_t;

    typedef struct packed {
        op_t                    op;
        logic [4:0]             rd;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [31:0]            imm;
        logic [`M_WIDTH-1:0]    pc;
        logic                   pred;
        logic [`LG_PHT_SZ-1:0]  pht_idx;
        logic [`M_WIDTH-1:0]    pred_target;
        logic                   serializing_op;
        logic                   must_restart;
        logic [3:0]             rob_ptr;
    } uop_t;
endpackage

module decode_riscv import decode_pkg::*; (
    input  logic [31:0]           insn,
    input  logic [`M_WIDTH-1:0]   pc,
    input  logic                  pred,
    input  logic [`LG_PHT_SZ-1:0] pht_idx,
    input  logic [`M_WIDTH-1:0]   pred_target,
    output uop_t                  uop
);
    // Classify the opcode and attach the fetch metadata; rob_ptr is left at 0
    always_comb begin
        uop             = '0;
        uop.rd          = insn[11:7];
        uop.rs1         = insn[19:15];
        uop.rs2         = insn[24:20];
        uop.imm         = {{20{insn[31]}}, insn[31:20]};
        uop.pc          = pc;
        uop.pred        = pred;
        uop.pht_idx     = pht_idx;
        uop.pred_target = pred_target;
        uop.op          = OP_II;
        case (insn[6:0])
            7'h13: uop.op = (insn[14:12] == 3'd0) ? OP_ADDI : OP_ALU;
            7'h33: uop.op = OP_ALU;
            7'h03: uop.op = OP_LOAD;
            7'h23: uop.op = OP_STORE;
            7'h63: uop.op = OP_BRANCH;
            7'h6f: uop.op = OP_JAL;
            7'h73: begin
                if (insn == 32'h0000_0073) begin
                    uop.op             = OP_BREAK;
                    uop.serializing_op = 1'b1;
                end else if (insn == 32'h0010_0073) begin
                    uop.op             = OP_MONITOR;
                    uop.serializing_op = 1'b1;
                    uop.must_restart   = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

module decode_ctrl import decode_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_insn,
    input  logic [`M_WIDTH-1:0]   in_pc,
    input  logic                  in_pred,
    input  logic [`LG_PHT_SZ-1:0] in_pht_idx,
    input  logic [`M_WIDTH-1:0]   in_pred_target,
    output logic                  out_valid,
    input  logic                  out_ready,
    output uop_t                  out_uop,
    input  logic                  rob_empty,
    input  logic                  serial_retire,
    output logic                  busy,
    output logic [31:0]           serial_stall_cycles
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          hold_restart_q, hold_restart_d;
    logic [31:0]   stall_q, stall_d;
    uop_t          mem_q [DEPTH];
    uop_t          dec_uop;
    uop_t          head_uop;
    logic          push;
    logic          pop;

    decode_riscv u_decode (
        .insn        (in_insn),
        .pc          (in_pc),
        .pred        (in_pred),
        .pht_idx     (in_pht_idx),
        .pred_target (in_pred_target),
        .uop         (dec_uop)
    );

    assign head_uop            = mem_q[head_q];
    assign out_uop             = head_uop;
    assign in_ready            = (int'(count_q) != DEPTH);
    assign busy                = (state_q != RUN);
    assign serial_stall_cycles = stall_q;

    // Serialization FSM, FIFO pointer bookkeeping and stall counting; flush overrides everything but the counter
    always_comb begin
        state_d        = state_q;
        hold_restart_d = hold_restart_q;
        out_valid      = 1'b0;
        case (state_q)
            RUN: begin
                out_valid = (count_q != '0) && !head_uop.serializing_op;
                if ((count_q != '0) && head_uop.serializing_op) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = rob_empty;
                if (rob_empty && out_ready) begin
                    state_d        = HOLD;
                    hold_restart_d = head_uop.must_restart;
                end
            end
            HOLD: begin
                if (!hold_restart_q && serial_retire) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        push    = in_valid && in_ready && !flush;
        pop     = out_valid && out_ready && !flush;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PW+1)'(1);
        end
        stall_d = stall_q + 32'(busy);

        if (flush) begin
            state_d        = RUN;
            hold_restart_d = 1'b0;
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
        end
    end

    // Control state registers, cleared immediately when reset goes low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            hold_restart_q <= 1'b0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            hold_restart_q <= hold_restart_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            stall_q        <= stall_d;
        end
    end

    // Uop storage; validity is tracked by count so the array needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= dec_uop;
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the decode controller.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

module tb_decode_ctrl;
    import decode_pkg::*;

    localparam int DEPTH = 4;
    localparam int PHT_W = `LG_PHT_SZ;
    localparam int PC_W  = `M_WIDTH;

    localparam int K_ADDI   = 0;
    localparam int K_ALUI   = 1;
    localparam int K_ALUR   = 2;
    localparam int K_LOAD   = 3;
    localparam int K_STORE  = 4;
    localparam int K_BRANCH = 5;
    localparam int K_JAL    = 6;
    localparam int K_BREAK  = 7;
    localparam int K_MON    = 8;
    localparam int K_ILL    = 9;
    localparam int K_SYS    = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_insn;
    logic [PC_W-1:0]       in_pc;
    logic                  in_pred;
    logic [PHT_W-1:0]      in_pht_idx;
    logic [PC_W-1:0]       in_pred_target;
    logic                  out_valid;
    logic                  out_ready;
    uop_t                  out_uop;
    logic                  rob_empty;
    logic                  serial_retire;
    logic                  busy;
    logic [31:0]           serial_stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    uop_t        model_q[$];
    uop_t        pending_uop;
    bit          draining;
    bit          holding;
    bit          hold_restart;
    logic [31:0] stall_exp;
    logic [PC_W-1:0] next_pc;

    always #5 clk = ~clk;

    decode_ctrl #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_insn             (in_insn),
        .in_pc               (in_pc),
        .in_pred             (in_pred),
        .in_pht_idx          (in_pht_idx),
        .in_pred_target      (in_pred_target),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_uop             (out_uop),
        .rob_empty           (rob_empty),
        .serial_retire       (serial_retire),
        .busy                (busy),
        .serial_stall_cycles (serial_stall_cycles)
    );

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Build an instruction of a given class; the class alone fixes the expected op
    function automatic void make_insn(input int kind, output logic [31:0] insn, output op_t op);
        logic [31:0] r = $urandom;
        case (kind)
            K_ADDI:   begin insn = {r[31:15], 3'b000, r[11:7], 7'h13}; op = OP_ADDI; end
            K_ALUI:   begin insn = {r[31:15], 3'($urandom_range(1, 7)), r[11:7], 7'h13}; op = OP_ALU; end
            K_ALUR:   begin insn = {r[31:7], 7'h33}; op = OP_ALU; end
            K_LOAD:   begin insn = {r[31:7], 7'h03}; op = OP_LOAD; end
            K_STORE:  begin insn = {r[31:7], 7'h23}; op = OP_STORE; end
            K_BRANCH: begin insn = {r[31:7], 7'h63}; op = OP_BRANCH; end
            K_JAL:    begin insn = {r[31:7], 7'h6f}; op = OP_JAL; end
            K_BREAK:  begin insn = 32'h0000_0073; op = OP_BREAK; end
            K_MON:    begin insn = 32'h0010_0073; op = OP_MONITOR; end
            K_ILL:    begin insn = {r[31:7], 7'h7f}; op = OP_II; end
            default:  begin insn = 32'h0020_0073; op = OP_II; end
        endcase
    endfunction

    function automatic int pick_kind();
        int r = int'($urandom_range(0, 99));
        if (r < 5)  return K_BREAK;
        if (r < 8)  return K_MON;
        if (r < 11) return K_ILL;
        if (r < 13) return K_SYS;
        return int'($urandom_range(0, 6));
    endfunction

    task automatic applyStimulus(input bit v, input int kind, input bit ordy, input bit robe, input bit sret, input bit fl);
        logic [31:0] insn;
        op_t         op;
        make_insn(kind, insn, op);
        in_valid       = v;
        in_insn        = insn;
        in_pc          = next_pc;
        in_pred        = 1'($urandom_range(0, 1));
        in_pht_idx     = PHT_W'($urandom);
        in_pred_target = PC_W'($urandom);
        out_ready      = ordy;
        rob_empty      = robe;
        serial_retire  = sret;
        flush          = fl;
        pending_uop                = '0;
        pending_uop.op             = op;
        pending_uop.rd             = insn[11:7];
        pending_uop.rs1            = insn[19:15];
        pending_uop.rs2            = insn[24:20];
        pending_uop.imm            = {{20{insn[31]}}, insn[31:20]};
        pending_uop.pc             = in_pc;
        pending_uop.pred           = in_pred;
        pending_uop.pht_idx        = in_pht_idx;
        pending_uop.pred_target    = in_pred_target;
        pending_uop.serializing_op = (op == OP_BREAK) || (op == OP_MONITOR);
        pending_uop.must_restart   = (op == OP_MONITOR);
    endtask

    function automatic bit model_out_valid();
        if (holding)  return 1'b0;
        if (draining) return rob_empty;
        return (model_q.size() > 0) && !model_q[0].serializing_op;
    endfunction

    // Advance the reference model by one clock using the values it predicted
    task automatic model_step(input bit ev, input bit er);
        bit was_busy = draining || holding;
        bit do_pop;
        bit do_push;
        if (was_busy) stall_exp = stall_exp + 32'd1;
        if (flush) begin
            model_q.delete();
            draining     = 1'b0;
            holding      = 1'b0;
            hold_restart = 1'b0;
            return;
        end
        do_pop  = ev && out_ready;
        do_push = in_valid && er;
        if (!was_busy && model_q.size() > 0 && model_q[0].serializing_op) begin
            draining = 1'b1;
        end else if (draining && do_pop) begin
            draining     = 1'b0;
            holding      = 1'b1;
            hold_restart = model_q[0].must_restart;
        end else if (holding && !hold_restart && serial_retire) begin
            holding = 1'b0;
        end
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
            model_q.push_back(pending_uop);
            next_pc = next_pc + PC_W'(4);
        end
    endtask

    task automatic run_cycle();
        bit ev;
        bit er;
        bit eb;
        #1;
        ev = model_out_valid();
        er = model_q.size() < DEPTH;
        eb = draining || holding;
        checkOutput("in_ready", 256'(in_ready), 256'(er));
        checkOutput("out_valid", 256'(out_valid), 256'(ev));
        checkOutput("busy", 256'(busy), 256'(eb));
        checkOutput("stall_cycles", 256'(serial_stall_cycles), 256'(stall_exp));
        if (ev && model_q.size() > 0) begin
            checkOutput("out_uop", 256'(out_uop), 256'(model_q[0]));
        end
        @(posedge clk);
        model_step(ev, er);
        @(negedge clk);
    endtask

    task automatic cyc(input bit v, input int kind, input bit ordy, input bit robe, input bit sret, input bit fl);
        applyStimulus(v, kind, ordy, robe, sret, fl);
        run_cycle();
    endtask

    task automatic model_reset();
        model_q.delete();
        draining     = 1'b0;
        holding      = 1'b0;
        hold_restart = 1'b0;
        stall_exp    = '0;
        next_pc      = '0;
    endtask

    // Push a serializing op, keep the ROB busy, then let it drain and follow with an ADDI
    task automatic serial_scenario(input int kind);
        cyc(1'b0, K_ADDI, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, kind, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, K_ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; in_pred = 1'b0;
        in_pht_idx = '0; in_pred_target = '0; out_ready = 1'b0; rob_empty = 1'b0;
        serial_retire = 1'b0;
        model_reset();
        pending_uop = '0;
        reset = 1'b0;
        #2;
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_in_ready", 256'(in_ready), 256'(1));
        checkOutput("reset_busy", 256'(busy), 256'(0));
        checkOutput("reset_stall", 256'(serial_stall_cycles), 256'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back ADDI stream at full rate
        for (int i = 0; i < 8; i++) cyc(1'b1, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        // Fill with rename stalled, fifth push held until drain starts
        for (int i = 0; i < 5; i++) cyc(1'b1, K_ADDI, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(i < 2, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        serial_scenario(K_BREAK);
        serial_scenario(K_MON);
        cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        // Fill the FIFO behind a held BREAK, then flush with a push offered
        cyc(1'b1, K_BREAK, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        // Steady push+pop with two entries resident, pointers wrap
        for (int i = 0; i < 2; i++) cyc(1'b1, K_ADDI, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 75), pick_kind(), ($urandom_range(0, 99) < 70),
                ($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 15),
                ($urandom_range(0, 99) < 3));
        end

        // Reset while a BREAK waits in DRAIN must clear outputs without a clock
        cyc(1'b0, K_ADDI, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, K_BREAK, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, K_ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, K_ADDI, 1'b0, 1'b0, 1'b0, 1'b0);
        rob_empty = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_out_valid", 256'(out_valid), 256'(0));
        checkOutput("async_in_ready", 256'(in_ready), 256'(1));
        checkOutput("async_busy", 256'(busy), 256'(0));
        checkOutput("async_stall", 256'(serial_stall_cycles), 256'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, K_ADDI, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Decode-stage controller between the fetch queue and rename. Accepts fetched instructions over a valid/ready handshake, decodes them through an internal `decode_riscv` instance, and buffers the resulting `uop_t` in a small FIFO. It sequences delivery to rename and enforces serialization for `serializing_op` uops (BREAK, MONITOR): it drains the ROB before issue, then blocks younger uops until the serializing op retires or the pipe is flushed.

## Interface

Parameters:
- `DEPTH`, default 4: uop FIFO entries; power of two, minimum 2.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `flush` input 1: pipeline flush; clears FIFO and FSM.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: decode_ctrl can accept the instruction.
- `in_insn` input 32: raw instruction.
- `in_pc` input `M_WIDTH: instruction PC.
- `in_pred` input 1: branch prediction bit.
- `in_pht_idx` input `LG_PHT_SZ: PHT index.
- `in_pred_target` input `M_WIDTH: predicted indirect target.
- `out_valid` output 1: uop available to rename.
- `out_ready` input 1: rename accepts the uop.
- `out_uop` output uop_t: head uop; `rob_ptr` is passed through as 0.
- `rob_empty` input 1: ROB holds no uops.
- `serial_retire` input 1: one-cycle pulse when the ROB retires a serializing uop.
- `busy` output 1: FSM is not in RUN.
- `serial_stall_cycles` output 32: count of cycles spent in DRAIN or HOLD.

## Operation

- Push when `in_valid && in_ready`. The decoded uop is written at the tail.
- Pop when `out_valid && out_ready`. The head pointer advances.
- `in_ready = (count != DEPTH)`. It does not account for a same-cycle pop, so a full FIFO always refuses a push.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is log2(DEPTH)+1 bits.
- A simultaneous push and pop leaves `count` unchanged.
- FSM states:
  - RUN:
    - `out_valid = !empty && !head.serializing_op`.
    - If the FIFO is non-empty and the head is serializing, go to DRAIN next cycle.
  - DRAIN:
    - `out_valid = rob_empty`. The head is the serializing uop.
    - On pop, latch `hold_restart = head.must_restart` and go to HOLD.
  - HOLD:
    - `out_valid = 0`. Pushes continue while not full.
    - If `hold_restart == 0`, `serial_retire` moves the FSM to RUN.
    - If `hold_restart == 1`, `serial_retire` is ignored and only `flush` exits HOLD.
- `flush`:
  - Has priority over push, pop and all FSM transitions.
  - Next cycle: FIFO empty (`count = 0`, both pointers 0), state RUN, `hold_restart = 0`.
  - The same-cycle push is dropped. The same-cycle pop is not counted as a handshake by rename.
- `busy = (state != RUN)`.
- `serial_stall_cycles`:
  - Increments by 1 in every cycle the state is DRAIN or HOLD; wraps at 2^32.
  - Not cleared by `flush`.
- `serial_retire` outside HOLD has no effect.

## Timing

- Reset (asynchronous assert, `reset == 0`):
  - `count = 0`, pointers 0, state RUN, `hold_restart = 0`, `serial_stall_cycles = 0`.
  - Therefore `out_valid = 0`, `in_ready = 1`, `busy = 0`.
- Reset asserted mid-operation discards all FIFO contents immediately. Release is synchronized externally.
- Latency, push to `out_valid`: 1 cycle, with no bypass for an empty FIFO.
- Sustained throughput: 1 uop/cycle in RUN with `out_ready` held high.
- Serializing uop at head, `rob_empty` already 1: RUN (cycle n), DRAIN with `out_valid` (n+1), HOLD (n+2) if popped at n+1.
- HOLD to RUN: the cycle after `serial_retire`. A non-serializing head asserts `out_valid` in that same cycle.
- `out_uop` is driven from FIFO storage and is stable while `out_valid && !out_ready`. `out_valid` may drop in RUN only through `flush`.

## Test plan

- Stream: 8 ADDI pushed back to back, `out_ready = 1` → `out_valid` from cycle 1, 8 uops in order with PCs 0x0, 0x4, ..., 0x1C, and `in_ready` never deasserts.
- Fill: `out_ready = 0`, 5 pushes offered with `DEPTH = 4` → `in_ready` falls after the 4th push and the 5th is held. Raising `out_ready` drains all 5 in order.
- BREAK (insn 0x00100073 decodes to MONITOR; also test 0x00000073 BREAK) at the head with `rob_empty = 0` for 3 cycles, then 1 → `out_valid` stays 0 through those 3 cycles, issues once `rob_empty = 1`, then HOLD.
  - A following ADDI is not issued until `serial_retire` pulses for BREAK.
  - For MONITOR, the ADDI is not issued until `flush`.
- Flush while full and in HOLD → next cycle `count = 0`, `busy = 0`, `out_valid = 0`. The same-cycle push is dropped.
- Simultaneous push and pop at `count = 2` for 10 cycles → `count` stays 2 and the pointers wrap correctly. `serial_stall_cycles` equals the number of DRAIN+HOLD cycles observed across the test.
- Reset asserted during DRAIN → `out_valid = 0`, `in_ready = 1`, `serial_stall_cycles = 0` asynchronously, before the next clock edge.
